pe_row_collector: RTL and testbench

- Receiving end of the 8-PE systolic row (pe_8e x8). Lane i presents valid_out/out_sum one cycle after lane i-1.
- Captures the skewed 32-bit partial sums and requantizes each to int8 (round, shift, optional ReLU, saturate).
- Packs 8 channels into one 64-bit ofmap word in the same byte order as the activation words (lane 0 in [63:56]).
- Pushes words through a small FIFO to the ofmap SRAM writer over a valid/ready handshake with an address.

---
 rtl/pe_row_pkg.sv | 47 ++++
 rtl/pe_row_collector_fifo.sv | 65 ++++++
 rtl/pe_row_collector.sv | 167 ++++++++++++++++
 tb/tb_pe_row_collector.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_row_pkg.sv
// Shared definitions for the PE row collector: widths, FSM states and the
// int8 requantization function used by the capture path.
package pe_row_pkg;

    localparam int LANES_DEF = 8;
    localparam int SUM_W     = 32;
    localparam int BYTE_W    = 8;
    localparam int SHIFT_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } collector_state_t;

    // Round-half-up right shift with optional ReLU, saturated to signed int8.
    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic signed [BYTE_W-1:0] requant8(
        input logic signed [SUM_W-1:0] sum,
        input logic [SHIFT_W-1:0]      shift,
        input logic                    relu
    );
        logic signed [SUM_W:0] s;
        logic signed [SUM_W:0] rnd;
        logic signed [SUM_W:0] sat_max;
        logic signed [SUM_W:0] sat_min;
        sat_max = (SUM_W+1)'(127);
        sat_min = (SUM_W+1)'(-128);
        s = {sum[SUM_W-1], sum};
        if (relu && s[SUM_W]) begin
            s = '0;
        end
        if (shift != '0) begin
            rnd = (SUM_W+1)'(1) <<< (shift - 1'b1);
            s   = (s + rnd) >>> shift;
        end
        if (s > sat_max) begin
            requant8 = 8'sh7F;
        end else if (s < sat_min) begin
            requant8 = 8'sh80;
        end else begin
            requant8 = s[BYTE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pe_row_collector_fifo.sv
// Small register-based FIFO with a combinational head, full/empty flags and
// same-cycle push/pop (legal even when full).
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_reg[rd_ptr_reg];

    // Storage: each entry loads only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/pe_row_collector.sv
// Collects skewed partial sums from one systolic PE row, requantizes each to
// int8, packs a full group into one 64-bit ofmap word (lane 0 in the top
// byte) and hands words to the SRAM writer through a small FIFO.
module pe_row_collector
    import pe_row_pkg::*;
#(
    parameter int LANES      = LANES_DEF,
    parameter int SUM_BITS   = SUM_W,
    parameter int ADDR_BITS  = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_start,
    input  logic [ADDR_BITS-1:0]      cfg_base,
    input  logic [ADDR_BITS-1:0]      cfg_words,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic                      cfg_relu,
    input  logic [LANES-1:0]          pe_valid,
    input  logic [LANES*SUM_BITS-1:0] pe_sum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*BYTE_W-1:0]   out_data,
    output logic [ADDR_BITS-1:0]      out_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      err_ovf,
    output logic                      err_dup
);
    localparam int WORD_BITS = LANES * BYTE_W;

    collector_state_t     state_reg;
    collector_state_t     state_next;

    logic [ADDR_BITS-1:0] words_reg;
    logic [SHIFT_W-1:0]   shift_reg;
    logic                 relu_reg;
    logic [ADDR_BITS-1:0] acc_cnt_reg;
    logic [ADDR_BITS-1:0] push_cnt_reg;
    logic [ADDR_BITS-1:0] wr_addr_reg;
    logic [LANES-1:0]     mask_reg;
    logic [LANES-1:0]     mask_next;
    logic [BYTE_W-1:0]    lane_reg [LANES];
    logic [BYTE_W-1:0]    q_byte   [LANES];
    logic                 err_ovf_reg;
    logic                 err_dup_reg;

    logic                 start_job;
    logic [LANES-1:0]     lane_fire;
    logic [LANES-1:0]     dup_hit;
    logic                 group_full;
    logic                 push_req;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WORD_BITS-1:0] packed_word;

    assign start_job  = (state_reg == IDLE) && cfg_start;
    assign lane_fire  = (state_reg == RUN) ? pe_valid : '0;
    assign group_full = &mask_reg;
    // Groups beyond the configured word count are discarded, never pushed.
    assign push_req   = group_full && (push_cnt_reg != words_reg);
    assign pop        = out_valid && out_ready;

    // Per-lane quantization, mask update, duplicate detection and packing.
    // A completed mask clears on the push cycle, so a lane arriving on that
    // same cycle starts the next group.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign q_byte[gi]    = requant8(pe_sum[gi*SUM_BITS +: SUM_BITS], shift_reg, relu_reg);
            assign mask_next[gi] = (mask_reg[gi] && !group_full) || lane_fire[gi];
            assign dup_hit[gi]   = lane_fire[gi] && mask_reg[gi] && !group_full;
            assign packed_word[(LANES-1-gi)*BYTE_W +: BYTE_W] = lane_reg[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cfg_start) state_next = RUN;
            RUN:     if (push_cnt_reg == words_reg) state_next = DRAIN;
            DRAIN:   if (fifo_empty && (acc_cnt_reg == words_reg)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Job configuration, counters, address, lane capture and sticky errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_reg    <= '0;
            shift_reg    <= '0;
            relu_reg     <= 1'b0;
            acc_cnt_reg  <= '0;
            push_cnt_reg <= '0;
            wr_addr_reg  <= '0;
            mask_reg     <= '0;
            err_ovf_reg  <= 1'b0;
            err_dup_reg  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_reg[i] <= '0;
            end
        end else if (start_job) begin
            words_reg    <= cfg_words;
            shift_reg    <= cfg_shift;
            relu_reg     <= cfg_relu;
            acc_cnt_reg  <= '0;
            push_cnt_reg <= '0;
            wr_addr_reg  <= cfg_base;
            mask_reg     <= '0;
            err_ovf_reg  <= 1'b0;
            err_dup_reg  <= 1'b0;
        end else begin
            mask_reg <= mask_next;
            for (int i = 0; i < LANES; i++) begin
                if (lane_fire[i]) begin
                    lane_reg[i] <= q_byte[i];
                end
            end
            if (|dup_hit) begin
                err_dup_reg <= 1'b1;
            end
            if (push_req) begin
                push_cnt_reg <= push_cnt_reg + 1'b1;
                if (fifo_full && !pop) begin
                    err_ovf_reg <= 1'b1;
                end
            end
            if (pop) begin
                acc_cnt_reg <= acc_cnt_reg + 1'b1;
                wr_addr_reg <= wr_addr_reg + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (packed_word),
        .pop       (pop),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_addr  = wr_addr_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign err_ovf   = err_ovf_reg;
    assign err_dup   = err_dup_reg;

endmodule

// File: tb/tb_pe_row_collector.sv
// Scoreboard bench for pe_row_collector: directed jobs push expected words,
// a negedge monitor pops and compares each accepted word.
module tb_pe_row_collector;
    localparam int LANES     = 8;
    localparam int SUM_BITS  = 32;
    localparam int ADDR_BITS = 11;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      cfg_start;
    logic [ADDR_BITS-1:0]      cfg_base;
    logic [ADDR_BITS-1:0]      cfg_words;
    logic [4:0]                cfg_shift;
    logic                      cfg_relu;
    logic [LANES-1:0]          pe_valid;
    logic [LANES*SUM_BITS-1:0] pe_sum;
    logic                      out_valid;
    logic                      out_ready;
    logic [63:0]               out_data;
    logic [ADDR_BITS-1:0]      out_addr;
    logic                      busy;
    logic                      done;
    logic                      err_ovf;
    logic                      err_dup;

    pe_row_collector #(
        .LANES      (LANES),
        .SUM_BITS   (SUM_BITS),
        .ADDR_BITS  (ADDR_BITS),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_base  (cfg_base),
        .cfg_words (cfg_words),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .pe_valid  (pe_valid),
        .pe_sum    (pe_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .err_ovf   (err_ovf),
        .err_dup   (err_dup)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [63:0]          data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vals [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [ADDR_BITS-1:0] addr, input logic [63:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic start_job(input int base, input int words, input int shift, input logic relu);
        cfg_base  = ADDR_BITS'(base);
        cfg_words = ADDR_BITS'(words);
        cfg_shift = 5'(shift);
        cfg_relu  = relu;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_lane(input int lane, input int val);
        pe_valid = '0;
        pe_valid[lane] = 1'b1;
        pe_sum[lane*SUM_BITS +: SUM_BITS] = val;
        tick();
        pe_valid = '0;
    endtask

    task automatic send_vals();
        for (int i = 0; i < LANES; i++) begin
            send_lane(i, vals[i]);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int seen;
        seen = 0;
        for (int c = 0; c < budget && seen == 0; c++) begin
            tick();
            if (done) seen = 1;
        end
        check(name, 64'(seen), 64'd1);
        if (seen != 0) begin
            tick();
            check({name, "_pulse"}, 64'(done), 64'd0);
            check({name, "_idle"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"},  out_data,       64'd0);
        check({tag, "_out_addr"},  64'(out_addr),  64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_err_ovf"},   64'(err_ovf),   64'd0);
        check({tag, "_err_dup"},   64'(err_dup),   64'd0);
    endtask

    // Monitor: every accepted word is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%h@%0d required=none", out_data, out_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("WORD addr=%0d data=%h expected addr=%0d data=%h", out_addr, out_data, e.addr, e.data);
                check("sb_data", out_data, e.data);
                check("sb_addr", 64'(out_addr), 64'(e.addr));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nd;
        reset     = 1'b1;
        cfg_start = 1'b0;
        cfg_base  = '0;
        cfg_words = '0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        pe_valid  = '0;
        pe_sum    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset_checks("rst");
        reset = 1'b0;
        tick();

        // Single group, identity quantization, latency and done pulse.
        out_ready = 1'b1;
        start_job(100, 1, 0, 1'b0);
        check("t1_busy", 64'(busy), 64'd1);
        vals = '{1, 2, 3, 4, 5, 6, 7, 8};
        expect_word(11'd100, 64'h0102030405060708);
        send_vals();
        check("t1_lat_e", 64'(out_valid), 64'd0);
        tick();
        check("t1_lat_e1", 64'(out_valid), 64'd1);
        wait_done("t1_done", 20);
        check("t1_err_ovf", 64'(err_ovf), 64'd0);
        check("t1_err_dup", 64'(err_dup), 64'd0);

        // Requantization: round, shift, saturate, then with ReLU.
        vals = '{300, -300, 255, -129, 6, 7, -6, 0};
        start_job(200, 1, 1, 1'b0);
        expect_word(11'd200, 64'h7F807FC00304FD00);
        send_vals();
        wait_done("t2a_done", 20);
        start_job(201, 1, 1, 1'b1);
        expect_word(11'd201, 64'h7F007F0003040000);
        send_vals();
        wait_done("t2b_done", 20);

        // Back-pressure: six back-to-back groups into a 4-deep FIFO.
        out_ready = 1'b0;
        start_job(300, 6, 0, 1'b0);
        expect_word(11'd300, 64'h0102030405060708);
        expect_word(11'd301, 64'h1112131415161718);
        expect_word(11'd302, 64'h2122232425262728);
        expect_word(11'd303, 64'h3132333435363738);
        for (int g = 0; g < 6; g++) begin
            pe_valid = '1;
            for (int i = 0; i < LANES; i++) begin
                pe_sum[i*SUM_BITS +: SUM_BITS] = g*16 + i + 1;
            end
            tick();
        end
        pe_valid = '0;
        repeat (14) tick();
        check("t3_err_ovf", 64'(err_ovf), 64'd1);
        check("t3_err_dup", 64'(err_dup), 64'd0);
        check("t3_valid",   64'(out_valid), 64'd1);
        check("t3_hold_data", out_data, 64'h0102030405060708);
        tick();
        check("t3_hold_data2", out_data, 64'h0102030405060708);
        check("t3_hold_addr",  64'(out_addr), 64'd300);
        out_ready = 1'b1;
        repeat (6) tick();
        check("t3_drained", 64'(exp_q.size()), 64'd0);
        check("t3_empty",   64'(out_valid), 64'd0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) nd = 1;
        end
        check("t3_no_done", 64'(nd), 64'd0);
        check("t3_stuck_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset_checks("t3_rst");
        reset = 1'b0;
        tick();

        // Address wrap at the top of the ofmap SRAM.
        start_job(2046, 3, 0, 1'b0);
        expect_word(11'd2046, 64'h0001020304050607);
        expect_word(11'd2047, 64'h08090A0B0C0D0E0F);
        expect_word(11'd0,    64'h1011121314151617);
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < LANES; i++) vals[i] = g*8 + i;
            send_vals();
        end
        wait_done("t4_done", 20);

        // Duplicate lane: second value wins, err_dup sticky past done.
        start_job(500, 1, 0, 1'b0);
        expect_word(11'd500, 64'h0102034405060708);
        send_lane(0, 1);
        send_lane(1, 2);
        send_lane(2, 3);
        send_lane(3, 4);
        send_lane(3, 'h44);
        check("t5_err_dup", 64'(err_dup), 64'd1);
        send_lane(4, 5);
        send_lane(5, 6);
        send_lane(6, 7);
        send_lane(7, 8);
        wait_done("t5_done", 20);
        check("t5_dup_sticky", 64'(err_dup), 64'd1);

        // Reset mid-RUN after four lanes; new job must see no stale lanes.
        start_job(600, 1, 0, 1'b0);
        check("t6_dup_clr", 64'(err_dup), 64'd0);
        send_lane(0, 'h70);
        send_lane(1, 'h71);
        send_lane(2, 'h72);
        send_lane(3, 'h73);
        reset = 1'b1;
        #1;
        reset_checks("t6_rst");
        tick();
        reset = 1'b0;
        tick();
        start_job(700, 1, 0, 1'b0);
        send_lane(4, 'h15);
        send_lane(5, 'h16);
        send_lane(6, 'h17);
        send_lane(7, 'h18);
        repeat (3) tick();
        check("t6_no_stale", 64'(out_valid), 64'd0);
        expect_word(11'd700, 64'h1112131415161718);
        send_lane(0, 'h11);
        send_lane(1, 'h12);
        send_lane(2, 'h13);
        send_lane(3, 'h14);
        wait_done("t6_done", 20);

        repeat (3) tick();
        check("sb_final_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
